dclk_tx: RTL and testbench
==========================

# dclk_tx

Serializing transmitter for the dual-clock serial link between routers. It sends one flit as a start bit followed by the flit LSB-first on a single wire. It then completes a handshake against the far-end receiver's `channel_busy` before it accepts the next flit. The block sits on the output side of a router port, in the receiver's write-clock (shift) domain; the receiver's `channel_busy` comes from the receiver's read-clock domain.

## Interface
Parameters:
- `routerid`, default -1: router index, debug/trace only.
- `port`, default "unknown": port label, debug/trace only.
- `ACK_TIMEOUT`, default 64: cycles to wait for `channel_busy` to rise before abandoning the handshake.

Ports (N = `PAYLOAD_SIZE+`ADDR_BITS):
- `clk`, input, 1: single clock, same clock as the receiver's shift clock `wclk`. Reset is asynchronous and active-low.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `valid`, input, 1: a flit is offered on `parallel_in`.
- `parallel_in`, input, N: flit, address and payload.
- `item_read`, output, 1: one-cycle pulse when the flit is latched; the producer drops or advances `valid` next cycle.
- `channel_busy`, input, 1: the receiver's busy flag, asynchronous to `clk`.
- `serial_out`, output, 1: serial line, low when idle.
- `tx_busy`, output, 1: high in any state other than IDLE.
- `ack_timeout`, output, 1: one-cycle pulse when the timeout expires.

## Operation
- `channel_busy` passes through a 2-flop synchronizer giving `busy_s`; reset value 0.
- **Shift register** `sreg`, N bits:
  - Loaded with `parallel_in` on accept, shifted right by one each SEND cycle after the start bit.
  - Cleared when returning to IDLE.
- **Bit counter** `cnt`, width $clog2(N+1); counts 0..N inside SEND.
- **States:**
  - **IDLE:** `serial_out`=0.
    - `valid & !busy_s` → accept: `item_read`=1 that cycle, load `sreg`, `cnt`=0, go to SEND.
    - `valid & busy_s` → no accept; stay in IDLE.
  - **SEND:**
    - `cnt`=0: `serial_out`=1 (start bit).
    - `cnt`=k, 1..N: `serial_out`=`parallel_in` bit k-1 as latched, LSB-first.
    - After `cnt`=N, go to WAIT_BUSY with `serial_out`=0.
    - Total line activity: exactly N+1 cycles.
  - **WAIT_BUSY:** a timer counts up from 0.
    - `busy_s`=1 → WAIT_FREE.
    - Timer reaches `ACK_TIMEOUT`-1 → pulse `ack_timeout`, go to IDLE.
  - **WAIT_FREE:** `busy_s`=0 → IDLE. There is no timeout here; the receiver holds busy until its consumer reads the flit.
- `valid` and `parallel_in` are ignored outside IDLE; `sreg` is not disturbed by input changes.
- `serial_out` is registered (flop output), never combinational from `valid`.

## Timing
- **Reset values:** state IDLE; `serial_out`=0, `item_read`=0, `tx_busy`=0, `ack_timeout`=0, `sreg`=0, `cnt`=0, timer=0.
- **Accept latency:** a valid flit seen in IDLE at edge t gives `item_read` high during cycle t. The start bit appears on `serial_out` from edge t+1, and the last data bit is held in cycle t+N+1.
- **Minimum flit-to-flit spacing:** N+1 SEND cycles, plus 1 WAIT_BUSY cycle, plus ≥1 WAIT_FREE cycle, plus 1 IDLE cycle, plus synchronizer delay (2 cycles per edge of `busy_s`).
- **Reset mid-operation:** asserting `reset_n` low drops `serial_out` to 0 immediately (asynchronous). The half-sent flit is lost. The receiver is reset by the same system reset.
- **`busy_s` already high at WAIT_BUSY entry:** move to WAIT_FREE on the next edge; no timer count is needed.
- **`valid` high on the cycle of IDLE re-entry:** not accepted until the next edge. IDLE always lasts at least one cycle.

## Structure
- `PAYLOAD_SIZE` and `ADDR_BITS` come from the shared defines include already used by the link/router files.
- The state encoding (2-bit localparams IDLE/SEND/WAIT_BUSY/WAIT_FREE) stays local to this block.
- One sub-module: `sync2`, a generic 2-flop synchronizer with async active-low reset. It is reusable by other clock-crossing link blocks.

## Test plan
Bench defines: `PAYLOAD_SIZE`=8, `ADDR_BITS`=4 (N=12).
- **Single flit:** `parallel_in`=12'hA53, `busy` idle → `item_read` 1 cycle. `serial_out` sequence is 1, then 1,1,0,0,1,0,1,0,0,1,0,1, then 0. `tx_busy` is high from the first SEND cycle.
- **Loopback:** connect `dclk_rx` with `wclk`=`clk` and an `rclk` at a different frequency; send 12'h001, 12'hFFF, 12'h800 → the receiver's `parallel_out` matches each in order. No flit is accepted while `busy_s`=1.
- **Backpressure:** hold `channel_busy`=1 with `valid`=1 in IDLE for 20 cycles → no `item_read` and `serial_out` stays 0. Release → accept 3 cycles later (2 synchronizer cycles plus the accept edge).
- **Timeout:** no receiver (`channel_busy` tied 0), send 12'h123 → `ack_timeout` pulses exactly 64 cycles after WAIT_BUSY entry, then IDLE, then the next flit is accepted.
- **Reset mid-flit:** assert `reset_n` low after 5 data bits → `serial_out`=0 within the same cycle and all outputs at reset values. After release, 12'h5A5 is sent cleanly.

Source files
------------

// File: rtl/dclk_tx_pkg.sv
// Shared types and widths for the dual-clock link transmitter.
// Flit geometry falls back to the link defaults when the shared defines are absent.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

package dclk_tx_pkg;
  localparam int FLIT_W = `PAYLOAD_SIZE + `ADDR_BITS;
  localparam int CNT_W  = $clog2(FLIT_W + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_FREE = 2'd3
  } tx_state_e;
endpackage

// File: rtl/dclk_tx_sync2.sv
// Generic two-flop synchronizer for single-bit level signals crossing into clk.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/dclk_tx.sv
// Serial link transmitter: start bit plus LSB-first flit, then a busy/free
// handshake with the far-end receiver before the next flit is taken.
module dclk_tx
  import dclk_tx_pkg::*;
#(
  parameter int    routerid    = -1,
  parameter string port        = "unknown",
  parameter int    ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic [FLIT_W-1:0] parallel_in,
  output logic              item_read,
  input  logic              channel_busy,
  output logic              serial_out,
  output logic              tx_busy,
  output logic              ack_timeout,
  output logic [1:0]        dbg_state_o
);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLIT_W);

  // routerid/port only label the instance in hierarchy dumps and traces.
  if ((routerid < -1) || (port == "")) begin : g_label_check
  end

  tx_state_e         state_q, state_d;
  logic [FLIT_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              serial_q, serial_d;
  logic              item_read_q, item_read_d;
  logic              ack_q, ack_d;
  logic              busy_s;

  sync2 u_busy_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (channel_busy),
    .q_o     (busy_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      serial_q    <= 1'b0;
      item_read_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      serial_q    <= serial_d;
      item_read_q <= item_read_d;
      ack_q       <= ack_d;
    end
  end

  // serial_d is the line value for the next cycle, so the line trails the state by one.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    timer_d     = '0;
    serial_d    = 1'b0;
    item_read_d = 1'b0;
    ack_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid && !busy_s) begin
          item_read_d = 1'b1;
          sreg_d      = parallel_in;
          cnt_d       = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (cnt_q == '0) begin
          serial_d = 1'b1;
        end else begin
          serial_d = sreg_q[0];
          sreg_d   = sreg_q >> 1;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_BUSY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (busy_s) begin
          state_d = WAIT_FREE;
        end else if (timer_q == TMR_LAST) begin
          ack_d   = 1'b1;
          sreg_d  = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_FREE: begin
        if (!busy_s) begin
          sreg_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign serial_out  = serial_q;
  assign item_read   = item_read_q;
  assign ack_timeout = ack_q;
  assign tx_busy     = (state_q != IDLE);
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_dclk_tx.sv
// Directed bench for dclk_tx: single flit, timeout, backpressure,
// loopback against a behavioural receiver, and reset mid-flit.
module tb_dclk_tx;
  localparam int N = dclk_tx_pkg::FLIT_W;

  logic         clk = 1'b0;
  logic         rclk = 1'b0;
  logic         reset_n;
  logic         valid;
  logic [N-1:0] parallel_in;
  logic         item_read;
  logic         channel_busy;
  logic         serial_out;
  logic         tx_busy;
  logic         ack_timeout;
  logic [1:0]   dbg_state;

  logic         tb_busy;
  logic         loop_en = 1'b0;
  logic         rx_busy = 1'b0;
  logic         rx_full = 1'b0;
  logic [N-1:0] rx_sh = '0;
  int           rx_cnt = 0;
  int           rx_hold = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always #7 rclk = ~rclk;

  assign channel_busy = loop_en ? rx_busy : tb_busy;

  dclk_tx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid        (valid),
    .parallel_in  (parallel_in),
    .item_read    (item_read),
    .channel_busy (channel_busy),
    .serial_out   (serial_out),
    .tx_busy      (tx_busy),
    .ack_timeout  (ack_timeout),
    .dbg_state_o  (dbg_state)
  );

  // Receiver shift side, on the shared write clock.
  always @(posedge clk) begin
    if (loop_en) begin
      if (rx_cnt == 0) begin
        if (serial_out) rx_cnt <= 1;
      end else begin
        rx_sh[rx_cnt-1] <= serial_out;
        if (rx_cnt == N) begin
          rx_full <= 1'b1;
          rx_cnt  <= 0;
        end else begin
          rx_cnt <= rx_cnt + 1;
        end
      end
      if (rx_full && rx_busy) rx_full <= 1'b0;
    end
  end

  // Receiver read side: raise busy, hold it a few rclk cycles, then free the channel.
  always @(posedge rclk) begin
    if (!loop_en) begin
      rx_busy <= 1'b0;
      rx_hold <= 0;
    end else if (!rx_busy) begin
      if (rx_full) begin
        rx_busy <= 1'b1;
        rx_hold <= 3;
        got_q.push_back(rx_sh);
      end
    end else if (rx_hold == 0) begin
      rx_busy <= 1'b0;
    end else begin
      rx_hold <= rx_hold - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_item_read(input string tag, input int budget);
    int n = 0;
    while (item_read !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (item_read === 1'b1)
    else begin
      errors++;
      $error("FAIL %s: item_read observed 0 after %0d cycles, expected 1", tag, budget);
    end
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    while (ack_timeout !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (ack_timeout === 1'b1)
    else begin
      errors++;
      $error("FAIL %s: ack_timeout observed 0 after %0d cycles, expected 1", tag, budget);
    end
  endtask

  // Offer one flit in IDLE and check the whole line frame, LSB-first.
  task automatic send_and_check(input string tag, input logic [N-1:0] w);
    valid = 1'b1;
    parallel_in = w;
    tick();
    chk({tag, "_item_read"}, item_read, 1);
    chk({tag, "_tx_busy"}, tx_busy, 1);
    chk({tag, "_pre_start"}, serial_out, 0);
    valid = 1'b0;
    parallel_in = N'($urandom_range(0, (1 << N) - 1));
    tick();
    chk({tag, "_start"}, serial_out, 1);
    chk({tag, "_item_read_pulse"}, item_read, 0);
    for (int i = 0; i < N; i++) begin
      tick();
      chk($sformatf("%s_bit%0d", tag, i), serial_out, w[i]);
    end
    tick();
    chk({tag, "_line_idle"}, serial_out, 0);
  endtask

  initial begin
    logic exp_seq[N];
    logic [N-1:0] lb_words[3];
    int early;
    int n;

    reset_n = 1'b0;
    valid = 1'b0;
    parallel_in = '0;
    tb_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial", serial_out, 0);
    chk("rst_item_read", item_read, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_ack", ack_timeout, 0);
    chk("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    repeat (3) tick();

    // Single flit 12'hA53 against the hand-written line sequence.
    exp_seq = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
    valid = 1'b1;
    parallel_in = 12'hA53;
    tick();
    chk("a53_item_read", item_read, 1);
    chk("a53_tx_busy", tx_busy, 1);
    valid = 1'b0;
    parallel_in = 12'h000;
    tick();
    chk("a53_start", serial_out, 1);
    chk("a53_item_read_pulse", item_read, 0);
    for (int i = 0; i < N; i++) begin
      tick();
      chk($sformatf("a53_bit%0d", i), serial_out, exp_seq[i]);
    end
    tick();
    chk("a53_line_idle", serial_out, 0);
    wait_ack("a53_timeout", 100);
    tick();
    chk("a53_back_idle", tx_busy, 0);

    // Timeout: WAIT_BUSY entered 13 edges after accept, ack 64 edges later.
    valid = 1'b1;
    parallel_in = 12'h123;
    tick();
    chk("to_item_read", item_read, 1);
    valid = 1'b0;
    early = 0;
    for (int i = 0; i < 76; i++) begin
      tick();
      if (ack_timeout) early++;
    end
    chk("to_no_early_ack", early, 0);
    tick();
    chk("to_ack_pulse", ack_timeout, 1);
    chk("to_idle", tx_busy, 0);
    tick();
    chk("to_ack_one_cycle", ack_timeout, 0);
    send_and_check("to_next", 12'h0F0);
    wait_ack("to_next_timeout", 100);
    tick();

    // Backpressure: no accept while busy, accept three edges after release.
    tb_busy = 1'b1;
    repeat (3) tick();
    valid = 1'b1;
    parallel_in = 12'h3C3;
    early = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (item_read || serial_out) early++;
    end
    chk("bp_held_off", early, 0);
    tb_busy = 1'b0;
    tick();
    chk("bp_rel1", item_read, 0);
    tick();
    chk("bp_rel2", item_read, 0);
    tick();
    chk("bp_accept", item_read, 1);
    valid = 1'b0;
    wait_ack("bp_timeout", 200);
    tick();

    // Loopback through the behavioural receiver.
    loop_en = 1'b1;
    lb_words = '{12'h001, 12'hFFF, 12'h800};
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1;
      parallel_in = lb_words[k];
      wait_item_read($sformatf("lb_accept%0d", k), 400);
      chk($sformatf("lb_prev_done%0d", k), got_q.size(), k);
      valid = 1'b0;
      exp_q.push_back(lb_words[k]);
      tick();
    end
    n = 0;
    while ((got_q.size() < 3 || tx_busy) && n < 600) begin
      tick();
      n++;
    end
    chk("lb_count", got_q.size(), 3);
    chk("lb_handshake_done", tx_busy, 0);
    while (exp_q.size() > 0) begin
      logic [N-1:0] e;
      logic [N-1:0] g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : '0;
      chk("lb_data", g, e);
    end
    loop_en = 1'b0;
    repeat (4) tick();

    // Reset mid-flit while data bit 5 (a 1) is on the line.
    valid = 1'b1;
    parallel_in = 12'h5A5;
    tick();
    chk("rm_item_read", item_read, 1);
    valid = 1'b0;
    tick();
    repeat (6) tick();
    chk("rm_line_high", serial_out, 1);
    reset_n = 1'b0;
    #1;
    chk("rm_serial", serial_out, 0);
    chk("rm_item_read0", item_read, 0);
    chk("rm_tx_busy", tx_busy, 0);
    chk("rm_ack", ack_timeout, 0);
    chk("rm_state", dbg_state, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    send_and_check("rm_resend", 12'h5A5);
    wait_ack("rm_timeout", 100);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
